// File: rtl/addr_offset_pipe.sv
// addr_offset_pipe: elastic multi-stage pipeline. Each stage adds its own
// offset to the address and carries the ID alongside it. The arithmetic wraps
// or saturates, and a per-transaction overflow flag stays set once raised.
// Also provides a synchronous flush and a registered occupancy count.
//
// Handshake: a stage accepts new data when it is empty or when the stage
// after it is accepting, so ready[i] = !valid[i] || ready[i+1], with
// ready[DEPTH] = out_ready. A transfer happens on any edge where the
// upstream valid and ready[i] are both high. The output transfers when
// out_valid && out_ready. A valid stage that is not being drained holds its
// contents unchanged. The ready path is purely combinational, with no skid
// buffer.
module addr_offset_pipe #(
    parameter int ADDR_W   = 8,
    parameter int ID_W     = 4,
    parameter int DEPTH    = 3,
    parameter int SATURATE = 0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [DEPTH*ADDR_W-1:0] stage_offsets,
    input  logic [ADDR_W-1:0]       in_address,
    input  logic [ID_W-1:0]         in_id,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       out_address,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        occupancy
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_nxt;
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  up_valid;
    logic [DEPTH-1:0]  cap;
    logic              all_valid;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  occ_q;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic              ovf_q  [DEPTH];
    logic [ADDR_W-1:0] up_addr [DEPTH];
    logic [ID_W-1:0]   up_id   [DEPTH];
    logic              up_ovf  [DEPTH];

    // Ready chain, unrolled. Stage i is ready unless it and every stage after
    // it are full while the output is stalled.
    always_comb begin
        all_valid = 1'b1;
        ready     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_valid = all_valid & valid_q[i];
            ready[i]  = out_ready | ~all_valid;
        end
    end

    // Stage inputs. Stage 0 takes the request; later stages take the previous
    // stage's registers.
    always_comb begin
        up_valid[0] = in_valid;
        up_addr[0]  = in_address;
        up_id[0]    = in_id;
        up_ovf[0]   = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            up_valid[i] = valid_q[i-1];
            up_addr[i]  = addr_q[i-1];
            up_id[i]    = id_q[i-1];
            up_ovf[i]   = ovf_q[i-1];
        end
    end

    // Next valids, capture enables and the next occupancy.
    // Flush overrides any capture.
    always_comb begin
        cap       = '0;
        valid_nxt = '0;
        cnt_nxt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cap[i]       = !flush && ready[i] && up_valid[i];
            valid_nxt[i] = flush ? 1'b0 : (ready[i] ? up_valid[i] : valid_q[i]);
            cnt_nxt      = cnt_nxt + CNT_W'(valid_nxt[i]);
        end
    end

    // Valid bits and occupancy advance together, so the count always matches
    // the number of valid stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_nxt;
            occ_q   <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [ADDR_W-1:0] off;
        logic [ADDR_W:0]   sum;
        logic [ADDR_W-1:0] res;

        assign off = stage_offsets[i*ADDR_W +: ADDR_W];
        assign sum = {1'b0, up_addr[i]} + {1'b0, off};
        assign res = (SATURATE != 0 && sum[ADDR_W]) ? {ADDR_W{1'b1}} : sum[ADDR_W-1:0];

        // Data registers load only on a real transfer. The offset is applied
        // at capture time, so later offset changes cannot touch held data.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                addr_q[i] <= '0;
                id_q[i]   <= '0;
                ovf_q[i]  <= 1'b0;
            end else if (cap[i]) begin
                addr_q[i] <= res;
                id_q[i]   <= up_id[i];
                ovf_q[i]  <= up_ovf[i] | sum[ADDR_W];
            end
        end
    end

    assign in_ready    = ready[0] && !flush && !reset;
    assign out_valid   = valid_q[DEPTH-1];
    assign out_address = addr_q[DEPTH-1];
    assign out_id      = id_q[DEPTH-1];
    assign out_ovf     = ovf_q[DEPTH-1];
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_addr_offset_pipe.sv
// tb_addr_offset_pipe: bench with two instances, one wrapping and one
// saturating, driven from the same inputs. A transaction-level model
// computes each expected output from the offsets at acceptance time.
module tb_addr_offset_pipe;

    localparam int ADDR_W = 8;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 2;
    localparam int EXP_W  = ID_W + 2 * (ADDR_W + 1);

    // ---------------- clock / reset / signals ----------------
    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [DEPTH*ADDR_W-1:0] stage_offsets;
    logic [ADDR_W-1:0]       in_address;
    logic [ID_W-1:0]         in_id;
    logic                    in_valid;
    logic                    out_ready;

    logic                    w_in_ready, s_in_ready;
    logic [ADDR_W-1:0]       w_out_address, s_out_address;
    logic [ID_W-1:0]         w_out_id, s_out_id;
    logic                    w_out_ovf, s_out_ovf;
    logic                    w_out_valid, s_out_valid;
    logic [CNT_W-1:0]        w_occ, s_occ;

    always #5 clk = ~clk;

    addr_offset_pipe #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .flush(flush), .stage_offsets(stage_offsets),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid), .in_ready(w_in_ready),
        .out_address(w_out_address), .out_id(w_out_id), .out_ovf(w_out_ovf),
        .out_valid(w_out_valid), .out_ready(out_ready), .occupancy(w_occ)
    );

    addr_offset_pipe #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .stage_offsets(stage_offsets),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_address(s_out_address), .out_id(s_out_id), .out_ovf(s_out_ovf),
        .out_valid(s_out_valid), .out_ready(out_ready), .occupancy(s_occ)
    );

    // ---------------- scoreboard state ----------------
    int checks    = 0;
    int failures  = 0;
    int delivered = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: fold the offsets with plain integer arithmetic.
    // Packed result: {id, ovf_sat, addr_sat, ovf_wrap, addr_wrap}.
    function automatic logic [EXP_W-1:0] model(input logic [ADDR_W-1:0] a,
                                               input logic [ID_W-1:0] id,
                                               input logic [DEPTH*ADDR_W-1:0] offs);
        int w, s, off, max_v;
        bit ovf_w, ovf_s;
        logic [ADDR_W-1:0] wa, sa;
        max_v = (1 << ADDR_W) - 1;
        w = int'(a); s = int'(a); ovf_w = 0; ovf_s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            off = int'(offs[i*ADDR_W +: ADDR_W]);
            w = w + off;
            s = s + off;
            if (w > max_v) begin w = w - (max_v + 1); ovf_w = 1; end
            if (s > max_v) begin s = max_v; ovf_s = 1; end
        end
        wa = ADDR_W'(w);
        sa = ADDR_W'(s);
        return {id, ovf_s, sa, ovf_w, wa};
    endfunction

    // ---------------- driver tasks ----------------
    // One cycle, entered at a negedge with inputs already driven.
    // Checks control outputs, scores any output handshake, updates the
    // model, then advances to the next negedge.
    task automatic step(output bit acc);
        logic [EXP_W-1:0] e;
        #1;
        chk("occupancy", 32'(w_occ), 32'(exp_q.size()));
        chk("occupancy_sat", 32'(s_occ), 32'(exp_q.size()));
        chk("in_ready", 32'(w_in_ready),
            32'(!flush && (exp_q.size() < DEPTH || out_ready)));
        chk("in_ready_sat", 32'(s_in_ready), 32'(w_in_ready));
        acc = in_valid && w_in_ready;
        if (exp_q.size() == 0) begin
            chk("idle_out_valid", 32'(w_out_valid), 32'd0);
        end else if (w_out_valid && out_ready) begin
            e = exp_q.pop_front();
            delivered++;
            chk("out_address_wrap", 32'(w_out_address), 32'(e[ADDR_W-1:0]));
            chk("out_ovf_wrap", 32'(w_out_ovf), 32'(e[ADDR_W]));
            chk("out_address_sat", 32'(s_out_address), 32'(e[2*ADDR_W:ADDR_W+1]));
            chk("out_ovf_sat", 32'(s_out_ovf), 32'(e[2*ADDR_W+1]));
            chk("out_id", 32'(w_out_id), 32'(e[EXP_W-1:EXP_W-ID_W]));
            chk("out_valid_sat", 32'(s_out_valid), 32'd1);
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(model(in_address, in_id, stage_offsets));
        @(negedge clk);
    endtask

    // Drain with out_ready high and no new input, within a cycle budget.
    task automatic drain();
        bit acc;
        in_valid = 0; flush = 0; out_ready = 1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(acc);
        step(acc);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Fill all stages with out_ready low.
    task automatic fill3(input logic [ID_W-1:0] base);
        bit acc;
        int n;
        n = 0; out_ready = 0; flush = 0;
        for (int c = 0; c < 20 && n < DEPTH; c++) begin
            in_valid = 1; in_id = base + ID_W'(n); in_address = 8'h40 + 8'(n);
            step(acc);
            if (acc) n++;
        end
        in_valid = 0;
        chk("fill_count", 32'(n), DEPTH);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [DEPTH*ADDR_W-1:0] offs;
        logic [ADDR_W-1:0]       addr;
        logic [ID_W-1:0]         id;
        logic [ADDR_W-1:0]       exp_w;
        logic [ADDR_W-1:0]       exp_s;
        logic                    exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        stage_offsets = v.offs; in_address = v.addr; in_id = v.id;
        in_valid = 1; out_ready = 1; flush = 0;
        #1 chk("vec_in_ready", 32'(w_in_ready), 32'd1);
        @(negedge clk);
        in_valid = 0;
        for (int c = 1; c <= DEPTH; c++) begin
            #1;
            if (c < DEPTH) begin
                chk("vec_early_valid", 32'(w_out_valid), 32'd0);
            end else begin
                chk("vec_out_valid", 32'(w_out_valid), 32'd1);
                chk("vec_addr_wrap", 32'(w_out_address), 32'(v.exp_w));
                chk("vec_addr_sat", 32'(s_out_address), 32'(v.exp_s));
                chk("vec_id", 32'(w_out_id), 32'(v.id));
                chk("vec_ovf_wrap", 32'(w_out_ovf), 32'(v.exp_ovf));
                chk("vec_ovf_sat", 32'(s_out_ovf), 32'(v.exp_ovf));
            end
            @(negedge clk);
        end
        #1 chk("vec_drained", 32'(w_occ), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        int n, d0;

        //            offsets {s2,s1,s0}      addr   id  wrap   sat    ovf
        vecs[0] = '{24'h030201, 8'h10, 4'd5, 8'h16, 8'h16, 1'b0};
        vecs[1] = '{24'h010101, 8'hFE, 4'd1, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{24'h010101, 8'h10, 4'd2, 8'h13, 8'h13, 1'b0};
        vecs[3] = '{24'h010101, 8'hFD, 4'd3, 8'h00, 8'hFF, 1'b1};
        vecs[4] = '{24'h008080, 8'h00, 4'd4, 8'h00, 8'hFF, 1'b1};
        vecs[5] = '{24'hFFFFFF, 8'hFF, 4'd6, 8'hFC, 8'hFF, 1'b1};
        vecs[6] = '{24'h000000, 8'h5A, 4'd7, 8'h5A, 8'h5A, 1'b0};
        vecs[7] = '{24'h404040, 8'h3F, 4'd8, 8'hFF, 8'hFF, 1'b0};

        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_address = '0; in_id = '0; stage_offsets = 24'h030201;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 32'(w_out_valid), 32'd0);
        chk("rst_in_ready", 32'(w_in_ready), 32'd0);
        chk("rst_occupancy", 32'(w_occ), 32'd0);
        chk("rst_out_address", 32'(w_out_address), 32'd0);
        chk("rst_out_id", 32'(w_out_id), 32'd0);
        chk("rst_out_ovf", 32'(w_out_ovf), 32'd0);
        reset = 0;
        @(negedge clk);

        // Single transactions: latency and arithmetic.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back stream 0x20..0x24 -> 0x26..0x2A on consecutive cycles.
        stage_offsets = 24'h030201; out_ready = 1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5); in_address = 8'h20 + 8'(c); in_id = ID_W'(c);
            #1;
            chk("stream_valid", 32'(w_out_valid), 32'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) chk("stream_addr", 32'(w_out_address), 32'h26 + 32'(c - 3));
            @(negedge clk);
        end
        in_valid = 0;

        // Backpressure: ids 0..4 with the output stalled, then released.
        d0 = delivered; n = 0; out_ready = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            in_valid = 1; in_id = ID_W'(n); in_address = 8'h30 + 8'(n);
            step(acc);
            if (acc) n++;
        end
        in_id = ID_W'(n); in_address = 8'h30 + 8'(n);
        #1;
        chk("bp_in_ready_low", 32'(w_in_ready), 32'd0);
        chk("bp_occ_full", 32'(w_occ), 32'd3);
        @(negedge clk);
        out_ready = 1;
        for (int c = 0; c < 20 && n < 5; c++) begin
            in_valid = 1; in_id = ID_W'(n); in_address = 8'h30 + 8'(n);
            step(acc);
            if (acc) n++;
        end
        drain();
        chk("bp_delivered", 32'(delivered - d0), 32'd5);
        chk("bp_occ_zero", 32'(w_occ), 32'd0);

        // Bubble collapse: two in, gap, one more, all while stalled.
        out_ready = 0;
        in_valid = 1; in_id = 4'hA; in_address = 8'h50;
        step(acc); chk("bub_acc0", 32'(acc), 32'd1);
        in_id = 4'hB; in_address = 8'h51;
        step(acc); chk("bub_acc1", 32'(acc), 32'd1);
        in_valid = 0;
        step(acc);
        in_valid = 1; in_id = 4'hC; in_address = 8'h52;
        step(acc); chk("bub_acc2", 32'(acc), 32'd1);
        in_id = 4'hD;
        #1;
        chk("bub_in_ready_low", 32'(w_in_ready), 32'd0);
        chk("bub_occ_full", 32'(w_occ), 32'd3);
        @(negedge clk);
        drain();

        // Flush while full and stalled; the offered input is refused.
        fill3(4'h1);
        flush = 1; in_valid = 1; in_id = 4'hF; in_address = 8'h77;
        step(acc);
        chk("flush_no_accept", 32'(acc), 32'd0);
        flush = 0; in_valid = 0;
        #1;
        chk("flush_occ", 32'(w_occ), 32'd0);
        chk("flush_out_valid", 32'(w_out_valid), 32'd0);
        @(negedge clk);
        drain();

        // Flush while full with output flowing: the head is still delivered.
        fill3(4'h4);
        d0 = delivered;
        flush = 1; out_ready = 1;
        step(acc);
        flush = 0;
        chk("flush_head_delivered", 32'(delivered - d0), 32'd1);
        drain();

        // Reset mid-operation: valids drop asynchronously.
        fill3(4'h8);
        #2 reset = 1;
        #1;
        chk("mid_rst_out_valid", 32'(w_out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(w_in_ready), 32'd0);
        chk("mid_rst_occ", 32'(w_occ), 32'd0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Randomized traffic against the model, offsets fixed per block.
        for (int blk = 0; blk < 4; blk++) begin
            drain();
            stage_offsets = (blk == 3) ? 24'hF0C080 : 24'($urandom);
            for (int c = 0; c < 300; c++) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                in_address = ADDR_W'($urandom_range(0, 255));
                in_id      = ID_W'($urandom_range(0, 15));
                out_ready  = ($urandom_range(0, 3) != 0);
                flush      = ($urandom_range(0, 39) == 0);
                step(acc);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_offset_pipe.md
Name: addr_offset_pipe

Overview:
- Parametrised multi-stage address-offset pipeline. Each stage adds its own offset to the address and carries the transaction ID alongside it.
- Uses a per-stage valid/ready elastic handshake, so a stalled output holds data in place instead of dropping it. Bubbles collapse.
- Sits between the request generator and the memory-side arbiter.
- Adds a selectable wrap/saturate mode, a sticky per-transaction overflow flag, a synchronous flush and an occupancy count.

Parameters:
- ADDR_W, 8, address width in bits (>=2).
- ID_W, 4, transaction ID width in bits (>=1).
- DEPTH, 3, number of register stages (1..16).
- SATURATE, 0, 0 = modulo-2^ADDR_W wrap; 1 = clamp at 2^ADDR_W-1.
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; invalidates all stages.
- stage_offsets  in  DEPTH*ADDR_W  stage i uses bits [i*ADDR_W +: ADDR_W].
- in_address  in  ADDR_W  request address.
- in_id  in  ID_W  request ID.
- in_valid  in  1  request valid.
- in_ready  out  1  pipeline accepts the request this cycle.
- out_address  out  ADDR_W  offset address from the last stage.
- out_id  out  ID_W  ID from the last stage.
- out_ovf  out  1  at least one stage wrapped or saturated for this transaction.
- out_valid  out  1  last stage holds data.
- out_ready  in  1  downstream accepts.
- occupancy  out  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (async, active-high): all stage valid, address, ID and ovf registers clear to 0. out_valid=0, out_address=0, out_id=0, out_ovf=0, occupancy=0.
- in_ready is combinational and is 0 while reset is asserted.
- Stage 0 input is in_*. Stage i>0 input is stage i-1 output. Stage DEPTH-1 output drives out_*.
- Handshake:
  - ready_DEPTH = out_ready.
  - ready_i = !valid_i || ready_(i+1).
  - in_ready = ready_0 && !flush.
  - Transfer into stage i occurs when upstream valid && ready_i.
  - The ready chain is combinational; no skid buffer.
- Capture at stage i: addr_i <= f(addr_in + off_i); id_i <= id_in; ovf_i <= ovf_in | carry_i. Stage 0 uses ovf_in = 0.
- Arithmetic: form the sum at ADDR_W+1 bits; carry_i = sum[ADDR_W].
  - SATURATE=0: result = sum[ADDR_W-1:0].
  - SATURATE=1: result = carry_i ? all-ones : sum[ADDR_W-1:0].
- The offset is sampled at capture time. Changing stage_offsets never alters data already held in a stage.
- Stage i held (valid_i && !ready_(i+1)): address, ID, ovf and valid are all frozen.
- Stage i drained with no new input: valid_i <= 0; data registers keep their old value (don't-care).
- Latency: DEPTH cycles from accepted input to out_valid when no stall occurs. Throughput is 1 per cycle.
- Ordering is strictly FIFO. No transaction is ever dropped or duplicated, except by flush or reset.
- Flush (sampled on clk): every valid_i <= 0 on that edge and the input is not accepted. Flush wins over a simultaneous capture or output handshake. The output handshake still completes if out_valid && out_ready in that cycle; downstream sees it as consumed.
- occupancy is a registered count of valid stages, updated on the same edge as the valids. It reads 0 the cycle after a flush.
- Reset mid-operation: all in-flight transactions are lost; valids clear immediately (async).
- DEPTH=1 degenerates to a single elastic register with identical rules.

Test Plan:
- ADDR_W=8, DEPTH=3, offsets {s0=0x01,s1=0x02,s2=0x03}, out_ready=1. Input addr 0x10 id 5 → out_valid rises 3 cycles later with addr 0x16, id 5, ovf 0. Then a back-to-back stream 0x20..0x24 → outputs 0x26..0x2A on consecutive cycles.
- Wrap (SATURATE=0): offsets all 0x01, input 0xFE → out 0x01, ovf 1. Input 0x10 → out 0x13, ovf 0.
- Saturate (SATURATE=1): offsets all 0x01, input 0xFE → out 0xFF, ovf 1. Input 0xFD → out 0xFF, ovf 1.
- Backpressure: out_ready=0 with 5 valid inputs ids 0..4. After 3 accepts, in_ready=0 and occupancy=3. Raise out_ready → ids 0..4 emerge in order, none lost; occupancy returns to 0.
- Bubble collapse: fill 2 stages, gap, then 1 input while out_ready=0 → all 3 stages fill and in_ready drops only when occupancy=3.
- Flush/reset: with occupancy=3 and out_ready=0, pulse flush one cycle → next cycle occupancy 0, out_valid 0, input offered that cycle not accepted. Repeat fill, assert reset mid-cycle → out_valid drops immediately, in_ready 0 during reset.
